// File: rtl/selftest_sequencer.sv
// Self-test sequencer: launches each attached self-test unit in turn, waits for
// its done/pass handshake (or a watchdog expiry) and accumulates the results.
module selftest_sequencer #(
  parameter int unsigned NUM_UNITS      = 7,
  parameter int unsigned START_IDX      = 0,
  parameter int unsigned RUN_COUNT      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           go,
  input  logic                           abort,
  input  logic [NUM_UNITS-1:0]           done_i,
  input  logic [NUM_UNITS-1:0]           pass_i,
  output logic [NUM_UNITS-1:0]           start_o,
  output logic                           busy,
  output logic                           suite_done,
  output logic                           aborted,
  output logic [$clog2(NUM_UNITS):0]     cur_idx,
  output logic [$clog2(NUM_UNITS):0]     pass_cnt,
  output logic [$clog2(NUM_UNITS):0]     fail_cnt,
  output logic [NUM_UNITS-1:0]           result_vec,
  output logic [NUM_UNITS-1:0]           timeout_vec
);

  localparam int unsigned IW  = $clog2(NUM_UNITS) + 1;
  localparam int unsigned CW  = IW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t               state, state_nxt;
  logic [WDW-1:0]       wd, wd_nxt;
  logic [NUM_UNITS-1:0] cur_mask;
  logic [NUM_UNITS-1:0] start_nxt, result_nxt, timeout_nxt;
  logic [IW-1:0]        idx_nxt, pass_nxt, fail_nxt;
  logic                 aborted_nxt;
  logic [CW-1:0]        completed;
  logic                 unit_done, unit_pass, wd_expired;

  // One-hot select of the unit currently being run
  assign cur_mask = NUM_UNITS'(1) << cur_idx;

  // Next-state, counter and result update logic
  always_comb begin
    state_nxt   = state;
    wd_nxt      = wd;
    idx_nxt     = cur_idx;
    pass_nxt    = pass_cnt;
    fail_nxt    = fail_cnt;
    result_nxt  = result_vec;
    timeout_nxt = timeout_vec;
    aborted_nxt = aborted;
    completed   = '0;
    unit_done   = |(done_i & cur_mask);
    unit_pass   = |(pass_i & cur_mask);
    wd_expired  = (wd == WDW'(TIMEOUT_CYCLES - 1));

    case (state)
      IDLE, DONE: begin
        if (go) begin
          state_nxt   = LAUNCH;
          idx_nxt     = IW'(START_IDX);
          pass_nxt    = '0;
          fail_nxt    = '0;
          result_nxt  = '0;
          timeout_nxt = '0;
          aborted_nxt = 1'b0;
        end
      end
      LAUNCH: begin
        wd_nxt = '0;
        if (abort) begin
          state_nxt   = DONE;
          aborted_nxt = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        wd_nxt = wd + WDW'(1);
        if (abort) begin
          state_nxt   = DONE;
          aborted_nxt = 1'b1;
        end else if (unit_done || wd_expired) begin
          // A real answer beats a watchdog expiry in the same cycle
          if (unit_done && unit_pass) begin
            pass_nxt   = pass_cnt + IW'(1);
            result_nxt = result_vec | cur_mask;
          end else begin
            fail_nxt = fail_cnt + IW'(1);
            if (!unit_done) timeout_nxt = timeout_vec | cur_mask;
          end
          completed = CW'(pass_nxt) + CW'(fail_nxt);
          if (((RUN_COUNT != 0) && (completed == CW'(RUN_COUNT))) ||
              (cur_idx == IW'(NUM_UNITS - 1))) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = cur_idx + IW'(1);
            state_nxt = LAUNCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    start_nxt = (state_nxt == LAUNCH) ? (NUM_UNITS'(1) << idx_nxt) : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wd          <= '0;
      start_o     <= '0;
      busy        <= 1'b0;
      suite_done  <= 1'b0;
      aborted     <= 1'b0;
      cur_idx     <= IW'(START_IDX);
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      result_vec  <= '0;
      timeout_vec <= '0;
    end else begin
      state       <= state_nxt;
      wd          <= wd_nxt;
      start_o     <= start_nxt;
      busy        <= (state_nxt == LAUNCH) || (state_nxt == WAIT);
      suite_done  <= (state_nxt == DONE);
      aborted     <= aborted_nxt;
      cur_idx     <= idx_nxt;
      pass_cnt    <= pass_nxt;
      fail_cnt    <= fail_nxt;
      result_vec  <= result_nxt;
      timeout_vec <= timeout_nxt;
    end
  end

endmodule
